// File: rtl/pad_hdx_pkg.sv
// Shared state type, parity helper and default sizing for the pad_hdx_ctrl
// half-duplex single-wire link controller.
package pad_hdx_pkg;

  localparam int unsigned PAD_HDX_DATA_WIDTH     = 8;
  localparam int unsigned PAD_HDX_BIT_CYCLES     = 4;
  localparam int unsigned PAD_HDX_TURN_CYCLES    = 2;
  localparam int unsigned PAD_HDX_TIMEOUT_CYCLES = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_PAR,
    ST_TURN,
    ST_WAIT,
    ST_RECV,
    ST_RPAR,
    ST_GUARD
  } pad_hdx_state_e;

  // Even parity: 1 when the word holds an odd number of ones.
  function automatic logic pad_hdx_even_par(input logic [63:0] i_word);
    return ^i_word;
  endfunction

endpackage

// File: rtl/pad_hdx_bitclk.sv
// Bit-period counter for pad_hdx_ctrl: emits a bit-boundary strobe and a
// mid-bit sample strobe; restartable to align with START or a start bit.
module pad_hdx_bitclk
  import pad_hdx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = PAD_HDX_BIT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_bit_end,
  output logic o_sample
);

  localparam int unsigned PCW = $clog2(BIT_CYCLES + 1);
  localparam logic [PCW-1:0] P_LAST    = PCW'(BIT_CYCLES - 1);
  localparam logic [PCW-1:0] P_MID     = PCW'(BIT_CYCLES / 2);
  // The restart cycle itself counts as phase 0, so the next cycle is phase 1.
  localparam logic [PCW-1:0] P_RESTART = PCW'(1 % BIT_CYCLES);

  logic [PCW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= P_RESTART;
    end else if (r_cnt == P_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PCW'(1);
    end
  end

  assign o_bit_end = (r_cnt == '0);
  assign o_sample  = (r_cnt == P_MID);

endmodule

// File: rtl/pad_hdx_ctrl.sv
// Half-duplex single-wire link controller behind a bidirectional pad.
// Optional even parity in both directions when PAD_HDX_PARITY_EN is defined.
module pad_hdx_ctrl
  import pad_hdx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = PAD_HDX_DATA_WIDTH,
  parameter int unsigned BIT_CYCLES     = PAD_HDX_BIT_CYCLES,
  parameter int unsigned TURN_CYCLES    = PAD_HDX_TURN_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PAD_HDX_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_rx_en,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_timeout,
  output logic                  rx_parity_err,
  output logic                  busy,
  output logic                  switch_mode_pad,
  output logic                  data_in_internal,
  input  logic                  data_out_internal
);

  localparam int unsigned BCW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned WMAX = (TURN_CYCLES > TIMEOUT_CYCLES) ? TURN_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned WCW  = $clog2(WMAX + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_WIDTH - 1);
  localparam logic [WCW-1:0] TURN_LAST = WCW'(TURN_CYCLES - 1);
  localparam logic [WCW-1:0] TO_LAST   = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic           SKIP_START = (BIT_CYCLES >= 2);

  pad_hdx_state_e        r_state;
  logic [DATA_WIDTH-1:0] r_txsh;
  logic [DATA_WIDTH-1:0] r_rxsh;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [BCW-1:0]        r_bcnt;
  logic [WCW-1:0]        r_wcnt;
  logic                  r_rx_en;
  logic                  r_skip;
  logic                  r_tx_ready;
  logic                  r_busy;
  logic                  r_sm;
  logic                  r_din;
  logic                  r_rx_valid;
  logic                  r_rx_timeout;
`ifdef PAD_HDX_PARITY_EN
  logic                  r_par;
  logic                  r_rx_perr;
`endif

  logic                  w_restart;
  logic                  w_bit_end;
  logic                  w_sample;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_restart = ((r_state == ST_IDLE) && tx_valid) ||
                     ((r_state == ST_WAIT) && !data_out_internal);
  assign w_rx_next = (r_rxsh << 1) | DATA_WIDTH'(data_out_internal);

  pad_hdx_bitclk #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bitclk (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_restart (w_restart),
    .o_bit_end (w_bit_end),
    .o_sample  (w_sample)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= ST_IDLE;
      r_txsh       <= '0;
      r_rxsh       <= '0;
      r_rx_data    <= '0;
      r_bcnt       <= '0;
      r_wcnt       <= '0;
      r_rx_en      <= 1'b0;
      r_skip       <= 1'b0;
      r_tx_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_sm         <= 1'b1;
      r_din        <= 1'b1;
      r_rx_valid   <= 1'b0;
      r_rx_timeout <= 1'b0;
`ifdef PAD_HDX_PARITY_EN
      r_par        <= 1'b0;
      r_rx_perr    <= 1'b0;
`endif
    end else begin
      r_rx_valid   <= 1'b0;
      r_rx_timeout <= 1'b0;
`ifdef PAD_HDX_PARITY_EN
      r_rx_perr    <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_state    <= ST_START;
            r_txsh     <= tx_data;
            r_rx_en    <= tx_rx_en;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_sm       <= 1'b0;
            r_din      <= 1'b0;
`ifdef PAD_HDX_PARITY_EN
            r_par      <= pad_hdx_even_par(64'(tx_data));
`endif
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_SEND;
            r_din   <= r_txsh[DATA_WIDTH-1];
            r_txsh  <= r_txsh << 1;
            r_bcnt  <= '0;
          end
        end
        ST_SEND: begin
          if (w_bit_end) begin
            if (r_bcnt == LAST_BIT) begin
`ifdef PAD_HDX_PARITY_EN
              r_state <= ST_PAR;
              r_din   <= r_par;
`else
              r_state <= r_rx_en ? ST_TURN : ST_GUARD;
              r_sm    <= 1'b1;
              r_din   <= 1'b1;
              r_wcnt  <= '0;
`endif
            end else begin
              r_bcnt <= r_bcnt + BCW'(1);
              r_din  <= r_txsh[DATA_WIDTH-1];
              r_txsh <= r_txsh << 1;
            end
          end
        end
`ifdef PAD_HDX_PARITY_EN
        ST_PAR: begin
          if (w_bit_end) begin
            r_state <= r_rx_en ? ST_TURN : ST_GUARD;
            r_sm    <= 1'b1;
            r_din   <= 1'b1;
            r_wcnt  <= '0;
          end
        end
`endif
        ST_TURN: begin
          if (r_wcnt == TURN_LAST) begin
            r_state <= ST_WAIT;
            r_wcnt  <= '0;
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
          end
        end
        ST_WAIT: begin
          if (!data_out_internal) begin
            r_state <= ST_RECV;
            r_bcnt  <= '0;
            r_skip  <= SKIP_START;
          end else if (r_wcnt == TO_LAST) begin
            r_state      <= ST_GUARD;
            r_rx_timeout <= 1'b1;
            r_wcnt       <= '0;
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
          end
        end
        ST_RECV: begin
          // With BIT_CYCLES>=2 the first mid-bit strobe lands inside the start bit.
          if (w_sample) begin
            if (r_skip) begin
              r_skip <= 1'b0;
            end else begin
              r_rxsh <= w_rx_next;
              if (r_bcnt == LAST_BIT) begin
`ifdef PAD_HDX_PARITY_EN
                r_state <= ST_RPAR;
`else
                r_state    <= ST_GUARD;
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                r_wcnt     <= '0;
`endif
              end else begin
                r_bcnt <= r_bcnt + BCW'(1);
              end
            end
          end
        end
`ifdef PAD_HDX_PARITY_EN
        ST_RPAR: begin
          if (w_sample) begin
            r_state    <= ST_GUARD;
            r_rx_data  <= r_rxsh;
            r_rx_valid <= 1'b1;
            r_rx_perr  <= pad_hdx_even_par(64'({r_rxsh, data_out_internal}));
            r_wcnt     <= '0;
          end
        end
`endif
        ST_GUARD: begin
          if (r_wcnt == TURN_LAST) begin
            r_state    <= ST_IDLE;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_sm       <= 1'b1;
          r_din      <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready         = r_tx_ready;
  assign busy             = r_busy;
  assign switch_mode_pad  = r_sm;
  assign data_in_internal = r_din;
  assign rx_valid         = r_rx_valid;
  assign rx_data          = r_rx_data;
  assign rx_timeout       = r_rx_timeout;
`ifdef PAD_HDX_PARITY_EN
  assign rx_parity_err    = r_rx_perr;
`else
  assign rx_parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pad_hdx_ctrl.sv
// Directed self-checking bench for pad_hdx_ctrl (default parameters).
module tb_pad_hdx_ctrl;

  localparam int DW = 8;
  localparam int BC = 4;
  localparam int TC = 2;
  localparam int TO = 16;
`ifdef PAD_HDX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB      = 1 + DW + P;
  localparam int RSP_DLY = 5;
  localparam int RXV_IDX = RSP_DLY + (DW + P) * BC + BC / 2 + 1;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b1;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_rx_en = 1'b0;
  logic          data_out_internal = 1'b1;
  logic          tx_ready, rx_valid, rx_timeout, rx_parity_err, busy;
  logic          switch_mode_pad, data_in_internal;
  logic [DW-1:0] rx_data;

  int n_tests = 0;
  int n_fail  = 0;

  int            rxv_cnt, rxv_idx, to_cnt, to_idx, perr_cnt, sm_bad, done_idx, busy_cyc;
  logic [DW-1:0] rxd;
  logic          perr_at_v, done;
  logic [DW-1:0] rsp_word;
  logic          rsp_par;
  int            rsp_dly;

  pad_hdx_ctrl #(
    .DATA_WIDTH     (DW),
    .BIT_CYCLES     (BC),
    .TURN_CYCLES    (TC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_data           (tx_data),
    .tx_rx_en          (tx_rx_en),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .rx_timeout        (rx_timeout),
    .rx_parity_err     (rx_parity_err),
    .busy              (busy),
    .switch_mode_pad   (switch_mode_pad),
    .data_in_internal  (data_in_internal),
    .data_out_internal (data_out_internal)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Responder line level in cycle c counted from the first released cycle.
  function automatic logic resp_line(input int c);
    int k;
    if (rsp_dly < 0 || c < rsp_dly) return 1'b1;
    k = (c - rsp_dly) / BC;
    if (k == 0) return 1'b0;
    if (k <= DW) return rsp_word[DW-k];
    if (k == DW + 1 && P == 1) return rsp_par;
    return 1'b1;
  endfunction

  task automatic accept(input logic [DW-1:0] d, input logic rxen);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_rx_en = rxen;
    check("ready_before_accept", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    busy_cyc = 0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic check_tx_bits(input logic [DW-1:0] d, input logic p);
    logic e;
    for (int b = 0; b < NB; b++) begin
      if (b == 0)       e = 1'b0;
      else if (b <= DW) e = d[DW-b];
      else              e = p;
      for (int c = 0; c < BC; c++) begin
        check($sformatf("tx_bit%0d_c%0d", b, c), {switch_mode_pad, data_in_internal}, {1'b0, e});
        if (busy) busy_cyc++;
        tick();
      end
    end
  endtask

  task automatic post_txn(input int dly, input logic [DW-1:0] w, input logic p);
    rsp_dly = dly; rsp_word = w; rsp_par = p;
    rxv_cnt = 0; rxv_idx = -1; to_cnt = 0; to_idx = -1; perr_cnt = 0; sm_bad = 0;
    done = 1'b0; done_idx = -1; perr_at_v = 1'b0; rxd = '0;
    for (int c = 0; c < 200; c++) begin
      data_out_internal = resp_line(c);
      if (switch_mode_pad !== 1'b1) sm_bad++;
      if (rx_valid) begin rxv_cnt++; rxv_idx = c; rxd = rx_data; perr_at_v = rx_parity_err; end
      if (rx_parity_err) perr_cnt++;
      if (rx_timeout) begin to_cnt++; to_idx = c; end
      if (!busy) begin done = 1'b1; done_idx = c; break; end
      busy_cyc++;
      tick();
    end
    data_out_internal = 1'b1;
    check("txn_completes", done, 1);
  endtask

  initial begin
    #1 PRESETn = 1'b0;
    #2;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_switch_mode", switch_mode_pad, 1);
    check("rst_data_in", data_in_internal, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_timeout", rx_timeout, 0);
    check("rst_parity_err", rx_parity_err, 0);
    check("rst_rx_data", rx_data, 0);
    tick(); tick();
    PRESETn = 1'b1;
    tick();
    check("idle_ready", tx_ready, 1);

    // Send-only 0xA5: line 0,1,0,1,0,0,1,0,1 then released.
    accept(8'hA5, 1'b0);
    check_tx_bits(8'hA5, 1'b0);
    post_txn(-1, '0, 1'b0);
    check("so_guard_len", done_idx, TC);
    check("so_busy_cycles", busy_cyc, NB * BC + TC);
    check("so_no_rx_valid", rxv_cnt, 0);
    check("so_no_timeout", to_cnt, 0);
    check("so_released", sm_bad, 0);

    // Send + receive 0x3C, responder starts 5 cycles after release.
    accept(8'h3C, 1'b1);
    check_tx_bits(8'h3C, 1'b0);
    post_txn(RSP_DLY, 8'h3C, 1'b0);
    check("sr_rx_valid_once", rxv_cnt, 1);
    check("sr_rx_valid_cycle", rxv_idx, RXV_IDX);
    check("sr_rx_data", rxd, 8'h3C);
    check("sr_no_parity_err", perr_cnt, 0);
    check("sr_no_timeout", to_cnt, 0);
    check("sr_released", sm_bad, 0);
    check("sr_rx_data_held", rx_data, 8'h3C);

    // Timeout: line held high after turnaround.
    accept(8'hF0, 1'b1);
    check_tx_bits(8'hF0, 1'b0);
    post_txn(-1, '0, 1'b0);
    check("to_pulse_once", to_cnt, 1);
    check("to_pulse_cycle", to_idx, TC + TO);
    check("to_no_rx_valid", rxv_cnt, 0);
    check("to_released", sm_bad, 0);
    check("to_rx_data_held", rx_data, 8'h3C);

`ifdef PAD_HDX_PARITY_EN
    // 0x07 sends parity 1; response 0x01 with parity 0 is a parity error.
    accept(8'h07, 1'b1);
    check_tx_bits(8'h07, 1'b1);
    post_txn(RSP_DLY, 8'h01, 1'b0);
    check("par_rx_valid_once", rxv_cnt, 1);
    check("par_rx_data", rxd, 8'h01);
    check("par_err_with_valid", perr_at_v, 1);
    check("par_err_once", perr_cnt, 1);
`endif

    // Asynchronous reset in the middle of SEND.
    accept(8'hA5, 1'b0);
    repeat (10) tick();
    check("mid_send_driving", switch_mode_pad, 0);
    #3 PRESETn = 1'b0;
    #1;
    check("arst_switch_mode", switch_mode_pad, 1);
    check("arst_data_in", data_in_internal, 1);
    check("arst_tx_ready", tx_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_rx_data", rx_data, 0);
    #2 PRESETn = 1'b1;
    tick();
    check("post_rst_ready", tx_ready, 1);
    check("post_rst_released", switch_mode_pad, 1);

    // Back-to-back: tx_valid held for two words.
    tx_valid = 1'b1; tx_data = 8'h5A; tx_rx_en = 1'b0;
    tick();
    tx_data = 8'h01;
    check_tx_bits(8'h5A, 1'b0);
    for (int g = 0; g < TC; g++) begin
      check("b2b_guard_released", switch_mode_pad, 1);
      check("b2b_guard_not_ready", tx_ready, 0);
      tick();
    end
    check("b2b_idle_ready", tx_ready, 1);
    check("b2b_idle_not_busy", busy, 0);
    tick();
    check("b2b_second_start", {switch_mode_pad, data_in_internal, busy}, 3'b001);
    tx_valid = 1'b0;
    busy_cyc = 0;
    check_tx_bits(8'h01, 1'b1);
    post_txn(-1, '0, 1'b0);
    check("b2b_second_guard", done_idx, TC);
    check("b2b_second_busy", busy_cyc, NB * BC + TC);
    check("b2b_released", sm_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
